mips_pipeline_memwb_queue: RTL and testbench

//  Parametrised MEM/WB pipeline stage: a DEPTH-entry elastic queue with valid/ready handshakes on both sides.
//  - Captures load-aligned write-back data in MEM.
//  - Drains it to the register-file write port in WB.
//  - Provides a youngest-first forwarding lookup for the EX hazard unit.
//  - Replaces the fixed single-register MEM/WB pack with stall, flush, sub-word loads and multi-entry buffering.

---
 rtl/mips_pipeline_memwb_queue_if.sv | 40 ++++
 rtl/mips_pipeline_memwb_queue.sv | 147 ++++++++++++++
 tb/tb_mips_pipeline_memwb_queue.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pipeline_memwb_queue_if.sv
// MEM/WB queue bus: MEM-side push, WB-side drain, EX forwarding query and flush.
interface mips_pipeline_memwb_queue_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned DEPTH  = 2
);
  logic                       flush;
  logic                       inValid;
  logic                       inReady;
  logic                       inRegWrite;
  logic                       inMemToReg;
  logic [REG_W-1:0]           inRegDst;
  logic [DATA_W-1:0]          inAluOut;
  logic [DATA_W-1:0]          inMemOut;
  logic [1:0]                 inLoadSize;
  logic                       inLoadSigned;
  logic                       outValid;
  logic                       outReady;
  logic                       outRegWrite;
  logic [REG_W-1:0]           outRegDst;
  logic [DATA_W-1:0]          outData;
  logic [REG_W-1:0]           fwdReg;
  logic                       fwdHit;
  logic [DATA_W-1:0]          fwdData;
  logic [$clog2(DEPTH):0]     count;

  // Pipeline control side: drives MEM entries, WB consume, forwarding query.
  modport master (
    output flush, inValid, inRegWrite, inMemToReg, inRegDst, inAluOut, inMemOut,
           inLoadSize, inLoadSigned, outReady, fwdReg,
    input  inReady, outValid, outRegWrite, outRegDst, outData, fwdHit, fwdData, count
  );

  // The queue itself.
  modport slave (
    input  flush, inValid, inRegWrite, inMemToReg, inRegDst, inAluOut, inMemOut,
           inLoadSize, inLoadSigned, outReady, fwdReg,
    output inReady, outValid, outRegWrite, outRegDst, outData, fwdHit, fwdData, count
  );
endinterface

// File: rtl/mips_pipeline_memwb_queue.sv
// MEM/WB pipeline stage as a DEPTH-entry elastic queue with load alignment on
// capture, head-entry drain to the register file and youngest-first forwarding.
module mips_pipeline_memwb_queue #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_W      = 5,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned BIG_ENDIAN = 1
) (
  input  logic                              clock,
  input  logic                              reset,
  mips_pipeline_memwb_queue_if.slave        bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  cnt;
  logic [DEPTH-1:0]  ent_valid;
  logic [DEPTH-1:0]  ent_wr;
  logic [REG_W-1:0]  ent_dst  [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];

  logic              in_ready;
  logic              not_empty;
  logic              push;
  logic              pop;
  logic              cap_wr;
  logic [DATA_W-1:0] cap_data;

  // Selects and extends the loaded byte/half from the aligned memory word.
  function automatic logic [DATA_W-1:0] load_data(
    input logic              mem_to_reg,
    input logic [1:0]        size,
    input logic              sgn,
    input logic [DATA_W-1:0] alu,
    input logic [DATA_W-1:0] mem
  );
    logic [DATA_W-1:0] shifted;
    logic [7:0]        b;
    logic [15:0]       h;
    int unsigned       bsel;
    int unsigned       hsel;
    int unsigned       shamt;
    bsel    = {30'b0, alu[1:0]};
    hsel    = {31'b0, alu[1]};
    shamt   = 0;
    shifted = '0;
    b       = '0;
    h       = '0;
    load_data = alu;
    if (mem_to_reg) begin
      case (size)
        2'd0: begin
          shamt     = (BIG_ENDIAN != 0) ? (DATA_W - 8 - 8 * bsel) : (8 * bsel);
          shifted   = mem >> shamt;
          b         = shifted[7:0];
          load_data = {{(DATA_W-8){sgn & b[7]}}, b};
        end
        2'd1: begin
          shamt     = (BIG_ENDIAN != 0) ? (DATA_W - 16 - 16 * hsel) : (16 * hsel);
          shifted   = mem >> shamt;
          h         = shifted[15:0];
          load_data = {{(DATA_W-16){sgn & h[15]}}, h};
        end
        default: load_data = mem;
      endcase
    end
  endfunction

  // Handshake qualification; inReady looks only at registered occupancy.
  always_comb begin
    in_ready  = (cnt != CNT_W'(DEPTH));
    not_empty = (cnt != '0);
    push      = bus.inValid & in_ready & ~bus.flush;
    pop       = not_empty & bus.outReady & ~bus.flush;
    cap_wr    = bus.inRegWrite & (bus.inRegDst != '0);
    cap_data  = load_data(bus.inMemToReg, bus.inLoadSize, bus.inLoadSigned,
                          bus.inAluOut, bus.inMemOut);
  end

  // Queue storage, pointers and occupancy; flush clears before push/pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      ent_valid <= '0;
      ent_wr    <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        ent_dst[k]  <= '0;
        ent_data[k] <= '0;
      end
    end else if (bus.flush) begin
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      ent_valid <= '0;
    end else begin
      // head == tail only when empty or full, so push and pop never share a slot.
      if (push) begin
        ent_valid[tail] <= 1'b1;
        ent_wr[tail]    <= cap_wr;
        ent_dst[tail]   <= bus.inRegDst;
        ent_data[tail]  <= cap_data;
        tail            <= tail + 1'b1;
      end
      if (pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Head entry to the WB port, zeroed when empty.
  always_comb begin
    bus.inReady     = in_ready;
    bus.outValid    = not_empty;
    bus.count       = cnt;
    bus.outRegWrite = not_empty ? ent_wr[head]   : 1'b0;
    bus.outRegDst   = not_empty ? ent_dst[head]  : '0;
    bus.outData     = not_empty ? ent_data[head] : '0;
  end

  // Forwarding: walk oldest to youngest so the youngest match is the last written.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx         = '0;
    bus.fwdHit  = 1'b0;
    bus.fwdData = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (ent_valid[idx] && ent_wr[idx] && (ent_dst[idx] == bus.fwdReg) &&
          (bus.fwdReg != '0)) begin
        bus.fwdHit  = 1'b1;
        bus.fwdData = ent_data[idx];
      end
    end
  end

endmodule

// File: tb/tb_mips_pipeline_memwb_queue.sv
// Bench for mips_pipeline_memwb_queue: table of capture/alignment vectors plus
// hand sequences for full, flush, forwarding and async reset; a scoreboard
// holds the expected queue contents.
module tb_mips_pipeline_memwb_queue;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DEPTH  = 2;

  logic clock;
  logic reset;

  mips_pipeline_memwb_queue_if #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH)) bus ();

  mips_pipeline_memwb_queue #(
    .DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH), .BIG_ENDIAN(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic [4:0]  dst;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [4:0]  dst;
    logic        m2r;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] alu;
    logic [31:0] mem;
    logic        exp_wr;
    logic [31:0] exp_data;
  } vec_t;

  exp_t sb[$];
  exp_t cur;
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Scoreboard monitor: compares state before each edge, then applies the
  // handshake the edge will perform to the expected queue.
  always @(negedge clock) begin
    logic        hit;
    logic [31:0] fdata;
    if (reset) begin
      sb.delete();
      check("rst_count", 64'(bus.count), 64'd0);
      check("rst_inReady", 64'(bus.inReady), 64'd1);
      check("rst_outValid", 64'(bus.outValid), 64'd0);
      check("rst_outRegWrite", 64'(bus.outRegWrite), 64'd0);
      check("rst_outRegDst", 64'(bus.outRegDst), 64'd0);
      check("rst_outData", 64'(bus.outData), 64'd0);
      check("rst_fwdHit", 64'(bus.fwdHit), 64'd0);
      check("rst_fwdData", 64'(bus.fwdData), 64'd0);
    end else begin
      check("count", 64'(bus.count), 64'(sb.size()));
      check("inReady", 64'(bus.inReady), 64'(sb.size() < DEPTH));
      check("outValid", 64'(bus.outValid), 64'(sb.size() != 0));
      if (sb.size() != 0) begin
        check("out_regwrite", 64'(bus.outRegWrite), 64'(sb[0].wr));
        check("out_regdst", 64'(bus.outRegDst), 64'(sb[0].dst));
        check("out_data", 64'(bus.outData), 64'(sb[0].data));
      end else begin
        check("empty_regwrite", 64'(bus.outRegWrite), 64'd0);
        check("empty_regdst", 64'(bus.outRegDst), 64'd0);
        check("empty_data", 64'(bus.outData), 64'd0);
      end
      hit   = 1'b0;
      fdata = '0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (!hit && sb[i].wr && sb[i].dst == bus.fwdReg && bus.fwdReg != 0) begin
          hit   = 1'b1;
          fdata = sb[i].data;
        end
      end
      check("fwd_hit", 64'(bus.fwdHit), 64'(hit));
      check("fwd_data", 64'(bus.fwdData), 64'(fdata));
      if (bus.flush) begin
        sb.delete();
      end else begin
        logic do_pop;
        logic do_push;
        do_pop  = (sb.size() != 0) && bus.outReady;
        do_push = bus.inValid && (sb.size() < DEPTH);
        if (do_pop) void'(sb.pop_front());
        if (do_push) sb.push_back(cur);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.inValid = 1'b0;
  endtask

  task automatic push_alu(input logic wr, input logic [4:0] dst, input logic [31:0] data);
    bus.inValid      = 1'b1;
    bus.inRegWrite   = wr;
    bus.inRegDst     = dst;
    bus.inMemToReg   = 1'b0;
    bus.inAluOut     = data;
    bus.inMemOut     = 32'hDEAD_BEEF;
    bus.inLoadSize   = 2'd2;
    bus.inLoadSigned = 1'b0;
    cur = '{wr: wr && (dst != 0), dst: dst, data: data};
  endtask

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{1, 5'd5,  0, 2'd2, 0, 32'h1234_5678, 32'hDEAD_BEEF, 1, 32'h1234_5678};
    vecs[1]  = '{1, 5'd6,  1, 2'd0, 1, 32'h1000_0000, 32'h80FF_7F01, 1, 32'hFFFF_FF80};
    vecs[2]  = '{1, 5'd7,  1, 2'd1, 0, 32'h1000_0002, 32'h80FF_7F01, 1, 32'h0000_7F01};
    vecs[3]  = '{1, 5'd8,  1, 2'd0, 0, 32'h1000_0000, 32'h80FF_7F01, 1, 32'h0000_0080};
    vecs[4]  = '{1, 5'd9,  1, 2'd0, 0, 32'h1000_0001, 32'h80FF_7F01, 1, 32'h0000_00FF};
    vecs[5]  = '{1, 5'd10, 1, 2'd0, 1, 32'h1000_0002, 32'h80FF_7F01, 1, 32'h0000_007F};
    vecs[6]  = '{1, 5'd11, 1, 2'd0, 1, 32'h1000_0003, 32'h80FF_7F01, 1, 32'h0000_0001};
    vecs[7]  = '{1, 5'd12, 1, 2'd1, 1, 32'h1000_0000, 32'h80FF_7F01, 1, 32'hFFFF_80FF};
    vecs[8]  = '{1, 5'd13, 1, 2'd1, 1, 32'h1000_0001, 32'h80FF_7F01, 1, 32'hFFFF_80FF};
    vecs[9]  = '{1, 5'd14, 1, 2'd1, 1, 32'h1000_0003, 32'h80FF_7F01, 1, 32'h0000_7F01};
    vecs[10] = '{1, 5'd15, 1, 2'd2, 1, 32'h1000_0001, 32'h80FF_7F01, 1, 32'h80FF_7F01};
    vecs[11] = '{1, 5'd16, 1, 2'd3, 0, 32'h1000_0002, 32'hCAFE_0123, 1, 32'hCAFE_0123};
    vecs[12] = '{1, 5'd0,  0, 2'd2, 0, 32'h0000_0042, 32'h0,         0, 32'h0000_0042};
    vecs[13] = '{0, 5'd17, 0, 2'd2, 0, 32'h0000_0043, 32'h0,         0, 32'h0000_0043};

    reset = 1'b1;
    bus.flush = 1'b0; bus.inValid = 1'b0; bus.inRegWrite = 1'b0; bus.inMemToReg = 1'b0;
    bus.inRegDst = '0; bus.inAluOut = '0; bus.inMemOut = '0; bus.inLoadSize = '0;
    bus.inLoadSigned = 1'b0; bus.outReady = 1'b0; bus.fwdReg = '0;
    cur = '{wr: 1'b0, dst: '0, data: '0};
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("t1_inReady", 64'(bus.inReady), 64'd1);
    check("t1_outValid", 64'(bus.outValid), 64'd0);
    check("t1_count", 64'(bus.count), 64'd0);

    // Basic push, latency 1, held at the head while outReady is low.
    step(); push_alu(1'b1, 5'd5, 32'h1234_5678);
    step(); idle();
    @(negedge clock);
    check("t2_outValid", 64'(bus.outValid), 64'd1);
    check("t2_outRegDst", 64'(bus.outRegDst), 64'd5);
    check("t2_outData", 64'(bus.outData), 64'h1234_5678);
    check("t2_count", 64'(bus.count), 64'd1);
    step(); bus.outReady = 1'b1;
    step(); bus.outReady = 1'b0;

    // Capture/alignment table, streamed with outReady high.
    bus.outReady = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      bus.inValid      = 1'b1;
      bus.inRegWrite   = vecs[i].wr;
      bus.inRegDst     = vecs[i].dst;
      bus.inMemToReg   = vecs[i].m2r;
      bus.inLoadSize   = vecs[i].size;
      bus.inLoadSigned = vecs[i].sgn;
      bus.inAluOut     = vecs[i].alu;
      bus.inMemOut     = vecs[i].mem;
      cur = '{wr: vecs[i].exp_wr, dst: vecs[i].dst, data: vecs[i].exp_data};
      bus.fwdReg = vecs[i].dst;
    end
    step(); idle();
    step(); bus.outReady = 1'b0; bus.fwdReg = '0;
    @(negedge clock);
    check("tbl_drained", 64'(bus.count), 64'd0);

    // Full queue, youngest-first forwarding, held third push.
    step(); push_alu(1'b1, 5'd3, 32'hAAAA_0001);
    step(); push_alu(1'b1, 5'd3, 32'hBBBB_0002);
    step(); idle(); bus.fwdReg = 5'd3;
    @(negedge clock);
    check("t4_count", 64'(bus.count), 64'd2);
    check("t4_inReady", 64'(bus.inReady), 64'd0);
    check("t4_fwdHit", 64'(bus.fwdHit), 64'd1);
    check("t4_fwdData", 64'(bus.fwdData), 64'hBBBB_0002);
    step(); push_alu(1'b1, 5'd9, 32'hCCCC_0003);
    step(); idle();
    @(negedge clock);
    check("t4_held_count", 64'(bus.count), 64'd2);
    check("t4_held_head", 64'(bus.outData), 64'hAAAA_0001);

    // Full with pop and push offered: pop only, then push+pop.
    step(); push_alu(1'b1, 5'd9, 32'hCCCC_0003); bus.outReady = 1'b1;
    step();
    @(negedge clock);
    check("t5_pop_only", 64'(bus.count), 64'd1);
    check("t5_head", 64'(bus.outData), 64'hBBBB_0002);
    step(); idle(); bus.outReady = 1'b0;
    @(negedge clock);
    check("t5_both", 64'(bus.count), 64'd1);
    check("t5_head2", 64'(bus.outData), 64'hCCCC_0003);

    // Flush beats a same-cycle push and pop.
    step(); push_alu(1'b1, 5'd4, 32'hDDDD_0004);
    step(); idle();
    @(negedge clock);
    check("t6_two", 64'(bus.count), 64'd2);
    step(); push_alu(1'b1, 5'd4, 32'hEEEE_0005); bus.flush = 1'b1; bus.outReady = 1'b1;
    step(); idle(); bus.flush = 1'b0; bus.outReady = 1'b0;
    @(negedge clock);
    check("t6_flush_count", 64'(bus.count), 64'd0);
    check("t6_flush_valid", 64'(bus.outValid), 64'd0);

    // r0 never writes or forwards; regWrite=0 entry never forwards.
    step(); push_alu(1'b1, 5'd0, 32'h5555_0000);
    step(); push_alu(1'b0, 5'd7, 32'h7777_0000); bus.fwdReg = 5'd0;
    @(negedge clock);
    check("t6_r0_regwrite", 64'(bus.outRegWrite), 64'd0);
    check("t6_r0_fwd", 64'(bus.fwdHit), 64'd0);
    step(); idle(); bus.fwdReg = 5'd7;
    @(negedge clock);
    check("t6_nowr_fwd", 64'(bus.fwdHit), 64'd0);

    // Asynchronous reset mid-operation drops everything before the next edge.
    step(); bus.fwdReg = 5'd0;
    #2 reset = 1'b1;
    #1;
    check("arst_count", 64'(bus.count), 64'd0);
    check("arst_valid", 64'(bus.outValid), 64'd0);
    step(); reset = 1'b0;
    step(); push_alu(1'b1, 5'd21, 32'h2121_2121);
    step(); idle(); bus.fwdReg = 5'd21;
    @(negedge clock);
    check("post_rst_fwd", 64'(bus.fwdData), 64'h2121_2121);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
